// File: rtl/rgb_pwm_driver.sv
// Active-low RGB LED PWM output stage with a one-deep colour buffer.
// A new colour takes effect only at a PWM period boundary.
module rgb_pwm_driver #(
  parameter int PRESCALE = 47
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       enable,
  output logic       period_start,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] prescale_r;
  logic [7:0]      pwm_cnt_r;
  logic            pending_r;
  logic [7:0]      pend_red_r;
  logic [7:0]      pend_grn_r;
  logic [7:0]      pend_blu_r;
  logic [7:0]      act_red_r;
  logic [7:0]      act_grn_r;
  logic [7:0]      act_blu_r;
  logic            tick_s;
  logic            boundary_s;
  logic            xfer_s;
  logic            on_red_s;
  logic            on_grn_s;
  logic            on_blu_s;

  // Step/period strobes, handshake and per-channel compare.
  always_comb begin
    tick_s     = (prescale_r == PS_LAST);
    boundary_s = tick_s && (pwm_cnt_r == 8'hFF);
    in_ready   = !pending_r;
    xfer_s     = in_valid && !pending_r;
    on_red_s   = (pwm_cnt_r < act_red_r);
    on_grn_s   = (pwm_cnt_r < act_grn_r);
    on_blu_s   = (pwm_cnt_r < act_blu_r);
  end

  // Prescaler and PWM step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_r <= '0;
      pwm_cnt_r  <= 8'd0;
    end else begin
      if (tick_s) begin
        prescale_r <= '0;
        pwm_cnt_r  <= pwm_cnt_r + 8'd1;
      end else begin
        prescale_r <= prescale_r + PS_W'(1);
      end
    end
  end

  // Pending buffer and active duties; a transfer needs pending clear, so it
  // never coincides with a load and is first applied at the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r  <= 1'b0;
      pend_red_r <= 8'd0;
      pend_grn_r <= 8'd0;
      pend_blu_r <= 8'd0;
      act_red_r  <= 8'd0;
      act_grn_r  <= 8'd0;
      act_blu_r  <= 8'd0;
    end else begin
      if (boundary_s && pending_r) begin
        act_red_r <= pend_red_r;
        act_grn_r <= pend_grn_r;
        act_blu_r <= pend_blu_r;
        pending_r <= 1'b0;
      end else if (xfer_s) begin
        pend_red_r <= in_r;
        pend_grn_r <= in_g;
        pend_blu_r <= in_b;
        pending_r  <= 1'b1;
      end
    end
  end

  // Registered period pulse and active-low LED pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start <= 1'b0;
      RGB_R        <= 1'b1;
      RGB_G        <= 1'b1;
      RGB_B        <= 1'b1;
    end else begin
      period_start <= boundary_s;
      RGB_R        <= ~(enable && on_red_s);
      RGB_G        <= ~(enable && on_grn_s);
      RGB_B        <= ~(enable && on_blu_s);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Randomised and directed bench for rgb_pwm_driver against a timeline model,
// plus period/low-time measurements on a PRESCALE=47 instance.
module tb_rgb_pwm_driver;

  localparam int P1 = 1;
  localparam int P2 = 47;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v1, en1, rdy1, ps1, R1, G1, B1;
  logic [7:0] r1, g1, b1;
  logic       v47, en47, rdy47, ps47, R47, G47, B47;
  logic [7:0] r47, g47, b47;

  int checks = 0;
  int errors = 0;

  // Timeline model of the PRESCALE=1 instance: edges since reset release.
  int m_n;
  bit m_pend_v;
  int m_pend[3];
  int m_act[3];
  bit m_rgb[3];
  bit m_ps;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(P1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
    .in_r(r1), .in_g(g1), .in_b(b1), .enable(en1),
    .period_start(ps1), .RGB_R(R1), .RGB_G(G1), .RGB_B(B1)
  );

  rgb_pwm_driver #(.PRESCALE(P2)) dut47 (
    .clk(clk), .rst_n(rst_n), .in_valid(v47), .in_ready(rdy47),
    .in_r(r47), .in_g(g47), .in_b(b47), .enable(en47),
    .period_start(ps47), .RGB_R(R47), .RGB_G(G47), .RGB_B(B47)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_pend_v = 1'b0;
    m_ps = 1'b0;
    for (int c = 0; c < 3; c++) begin
      m_pend[c] = 0;
      m_act[c]  = 0;
      m_rgb[c]  = 1'b1;
    end
  endtask

  // One clock: capture inputs, advance the model, compare after the edge.
  task automatic cyc();
    bit v, en, rdy, bnd;
    int inp[3];
    int cnt_prev;
    v = v1;
    en = en1;
    inp[0] = r1;
    inp[1] = g1;
    inp[2] = b1;
    @(posedge clk);
    cnt_prev = (m_n / P1) % 256;
    m_n++;
    for (int c = 0; c < 3; c++) m_rgb[c] = !(en && (cnt_prev < m_act[c]));
    bnd = (m_n % (256 * P1)) == 0;
    m_ps = bnd;
    rdy = !m_pend_v;
    if (bnd && m_pend_v) begin
      for (int c = 0; c < 3; c++) m_act[c] = m_pend[c];
      m_pend_v = 1'b0;
    end
    if (v && rdy) begin
      for (int c = 0; c < 3; c++) m_pend[c] = inp[c];
      m_pend_v = 1'b1;
    end
    #1;
    check_eq("in_ready", rdy1, !m_pend_v);
    check_eq("period_start", ps1, m_ps);
    check_eq("RGB_R", R1, m_rgb[0]);
    check_eq("RGB_G", G1, m_rgb[1]);
    check_eq("RGB_B", B1, m_rgb[2]);
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_R"}, R1, 1);
    check_eq({tag, "_G"}, G1, 1);
    check_eq({tag, "_B"}, B1, 1);
    check_eq({tag, "_rdy"}, rdy1, 1);
    check_eq({tag, "_ps"}, ps1, 0);
    check_eq({tag, "_R47"}, R47, 1);
    check_eq({tag, "_rdy47"}, rdy47, 1);
    check_eq({tag, "_ps47"}, ps47, 0);
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bit done;
    done = 1'b0;
    v1 = 1'b1;
    r1 = r;
    g1 = g;
    b1 = b;
    for (int i = 0; i < 600 && !done; i++) begin
      done = !m_pend_v;
      cyc();
    end
    v1 = 1'b0;
    check_eq("send_accept", done, 1);
  endtask

  task automatic wait_ps();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      cyc();
      seen = ps1;
    end
    check_eq("ps_wait", seen, 1);
  endtask

  // Low-cycle counts over one period; caller sits on a period_start cycle.
  task automatic measure(input string tag, input int er, input int eg, input int eb);
    int lr, lg, lb;
    lr = 0;
    lg = 0;
    lb = 0;
    for (int i = 0; i < 256 * P1; i++) begin
      cyc();
      if (R1 == 1'b0) lr++;
      if (G1 == 1'b0) lg++;
      if (B1 == 1'b0) lb++;
    end
    check_eq({tag, "_lowR"}, lr, er);
    check_eq({tag, "_lowG"}, lg, eg);
    check_eq({tag, "_lowB"}, lb, eb);
  endtask

  function automatic logic [7:0] rnd_duty();
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       return 8'd0;
      1:       return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int lows, n47, lr47, lg47;
    bit seen;
    rst_n = 1'b0;
    v1 = 1'b0; en1 = 1'b1; r1 = 8'd0; g1 = 8'd0; b1 = 8'd0;
    v47 = 1'b0; en47 = 1'b1; r47 = 8'd0; g47 = 8'd0; b47 = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks("init");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic colour, one full period measured.
    send(8'd64, 8'd0, 8'd255);
    wait_ps();
    measure("c1", 64, 0, 255);

    // Back-to-back: second colour held until the buffer frees.
    send(8'd10, 8'd20, 8'd30);
    v1 = 1'b1; r1 = 8'd200; g1 = 8'd200; b1 = 8'd200;
    wait_ps();
    measure("b2b_1", 10, 20, 30);
    v1 = 1'b0;
    measure("b2b_2", 200, 200, 200);

    // Transfer exactly on the boundary edge is deferred one period.
    while (((m_n + 1) % (256 * P1)) != 0) cyc();
    v1 = 1'b1; r1 = 8'd128; g1 = 8'd128; b1 = 8'd128;
    cyc();
    v1 = 1'b0;
    check_eq("bnd_ps", ps1, 1);
    measure("bnd_old", 200, 200, 200);
    measure("bnd_new", 128, 128, 128);

    // Enable gating keeps counters in phase.
    send(8'd255, 8'd255, 8'd255);
    wait_ps();
    measure("full", 255, 255, 255);
    repeat (100) cyc();
    en1 = 1'b0;
    wait_ps();
    measure("dis", 0, 0, 0);
    repeat (50) cyc();
    en1 = 1'b1;
    repeat (20) cyc();
    check_eq("pre_rst_R", R1, 0);

    // Asynchronous reset mid-period with a pending colour.
    v1 = 1'b1; r1 = 8'd99; g1 = 8'd99; b1 = 8'd99;
    cyc();
    v1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("async_rst");
    repeat (2) @(posedge clk);
    #1;
    reset_checks("held_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    lows = 0;
    for (int i = 0; i < 2 * 256 * P1 + 8; i++) begin
      cyc();
      if (R1 == 1'b0 || G1 == 1'b0 || B1 == 1'b0) lows++;
    end
    check_eq("dark_after_rst", lows, 0);

    // Randomised traffic with edge duties and enable toggling.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) en1 = ~en1;
      v1 = ($urandom_range(0, 2) == 0);
      r1 = rnd_duty();
      g1 = rnd_duty();
      b1 = rnd_duty();
      cyc();
    end
    v1 = 1'b0;
    en1 = 1'b1;

    // PRESCALE=47: period length and half-duty low time.
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("rst47");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    v47 = 1'b1; r47 = 8'd128; g47 = 8'd128; b47 = 8'd128;
    cyc();
    v47 = 1'b0;
    check_eq("rdy47_after_xfer", rdy47, 0);
    seen = 1'b0;
    for (int i = 0; i < 13000 && !seen; i++) begin
      cyc();
      seen = ps47;
    end
    check_eq("ps47_first", seen, 1);
    check_eq("rdy47_after_bnd", rdy47, 1);
    seen = 1'b0;
    n47 = 0;
    lr47 = 0;
    lg47 = 0;
    for (int i = 0; i < 13000 && !seen; i++) begin
      cyc();
      n47++;
      if (R47 == 1'b0) lr47++;
      if (G47 == 1'b0) lg47++;
      seen = ps47;
    end
    check_eq("ps47_second", seen, 1);
    check_eq("period47", n47, 12032);
    check_eq("low47_R", lr47, 6016);
    check_eq("low47_G", lg47, 6016);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Downstream output stage for the on-board RGB LED.
- Takes 8-bit per-channel intensities from a colour sequencer over a valid/ready handshake.
- Drives the active-low RGB_R/RGB_G/RGB_B pins with per-channel PWM.
- New intensities are double-buffered and applied only at a PWM period boundary, so colour changes are glitch-free.

Parameters:
- PRESCALE, 47: clk cycles per PWM step. PWM period = 256*PRESCALE cycles (≈997 Hz at 12 MHz). Legal range ≥1.

Ports:
- clk  in  1  system clock, 12 MHz
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents a new colour
- in_ready  out  1  driver can accept a colour
- in_r  in  8  red duty, 0 = off, 255 = on 255/256
- in_g  in  8  green duty
- in_b  in  8  blue duty
- enable  in  1  0 forces all LEDs off
- period_start  out  1  one-cycle pulse at the start of each PWM period
- RGB_R  out  1  red LED, active-low
- RGB_G  out  1  green LED, active-low
- RGB_B  out  1  blue LED, active-low

Behaviour:
- Reset is asynchronous and active-low. It clears:
  - prescaler and pwm_cnt to 0
  - active duties to 0 and pending duties to 0
  - pending flag to 0 and period_start to 0
  - RGB_R/G/B to 1 (off)
- in_ready is 1 while in reset and after reset.
- Prescaler counts 0..PRESCALE-1. tick = (prescaler == PRESCALE-1). On tick the prescaler returns to 0. With PRESCALE=1, tick is high every cycle.
- pwm_cnt is 8 bits and increments on tick, wrapping 255→0.
- boundary = tick && pwm_cnt == 255.
- On a boundary edge:
  - if the pending flag is set, active duties are loaded from the pending registers and the pending flag is cleared;
  - period_start is registered high for exactly the next cycle.
- Handshake:
  - in_ready = !pending (combinational from the flag).
  - Transfer occurs when in_valid && in_ready at a clk edge: pending registers capture in_r/in_g/in_b and the pending flag is set.
  - At most one colour is buffered. Pending is never overwritten.
  - in_valid held while in_ready=0 has no effect.
- Simultaneous transfer and boundary: the transfer can only occur when pending=0. The captured value is NOT applied at that boundary. It is applied at the next boundary, 256*PRESCALE cycles later (no bypass).
- Channel on = (pwm_cnt < active_duty), compared unsigned on 8 bits:
  - duty 0: never on
  - duty 255: on 255 of 256 steps
  - a full-on state does not exist
- Outputs are registered: RGB_x <= ~(enable && on_x). One cycle of latency from the pwm_cnt/active-duty state.
- enable=0 forces all outputs to 1 from the next edge. Counters, the handshake and period_start keep running unaffected.
- Reset asserted mid-period: outputs go to 1 immediately. Any pending colour is discarded. After release, output starts dark until a new colour is transferred and a boundary passes.

Test Plan:
- Reset: assert rst_n=0 mid-operation → RGB_R/G/B=1 with no clock edge needed; in_ready=1; period_start=0. After release, outputs stay 1 for ≥2 full periods with no input.
- PRESCALE=1, enable=1, transfer (64,0,255) → in_ready=0 the cycle after transfer. After the next period_start pulse, per 256-cycle period:
  - RGB_R low for exactly 64 cycles, then high for 192
  - RGB_G constantly high
  - RGB_B low for 255 cycles, high for 1
  - in_ready returns to 1 the cycle after the boundary.
- Back-to-back: transfer (10,20,30), then hold in_valid with (200,200,200) → second colour is not accepted until in_ready rises after the boundary. The following period shows duties 10/20/30. The period after that shows 200/200/200.
- Transfer of (128,128,128) on the exact boundary edge (pwm_cnt=255, tick=1) → previous duties persist for one full period; new duties take effect at the following period_start.
- enable deasserted mid-period with duties (255,255,255) → all outputs 1 from the next edge. period_start continues every 256*PRESCALE cycles. Re-enable → PWM resumes in phase with pwm_cnt, not restarted.
- PRESCALE=47 → period_start interval measures exactly 12032 cycles. Duty 128 gives a low time of exactly 6016 cycles per period.
